// File: rtl/hex_line_uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_line_uart_tx_pkg : shared constants, line FSM encoding, baud    |
// | divider helper.                            Rev 1.0                  |
// +--------------------------------------------------------------------+
package hex_line_uart_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef logic [2:0] line_state_t;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_CR   = 3'd3;
  localparam logic [2:0] S_LF   = 3'd4;

  typedef struct packed {
    int unsigned div;
    int unsigned width;
  } baud_cfg_t;

  // Bit period in clocks (truncated) and the counter width that holds 0..div-1.
  function automatic baud_cfg_t baud_div(input int unsigned clk_freq, input int unsigned baud);
    baud_cfg_t cfg;
    cfg.div   = clk_freq / baud;
    cfg.width = (cfg.div > 1) ? $clog2(cfg.div) : 1;
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_byte : single 8N1 frame serialiser with its own baud timer. |
// |                                            Rev 1.0                  |
// +--------------------------------------------------------------------+
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] byte_i,
  output logic       tx,
  output logic       done
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(BAUD_DIV - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [9:0]       r_frame;
  logic             w_bit_end;

  assign w_bit_end = r_active && (r_cnt == c_last);
  assign done      = w_bit_end && (r_idx == 4'd9);
  // Frame LSB is the line level; ones shift in behind so the line idles high.
  assign tx        = r_frame[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_frame  <= '1;
    end else if (!r_active) begin
      if (start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_frame  <= {1'b1, byte_i, 1'b0};
      end
    end else if (w_bit_end) begin
      r_cnt   <= '0;
      r_frame <= {1'b1, r_frame[9:1]};
      if (r_idx == 4'd9) begin
        r_active <= 1'b0;
        r_idx    <= '0;
      end else begin
        r_idx <= r_idx + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_line_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_line_uart_tx : sends an 8-character word as one UART line,      |
// | MSB character first, optionally terminated by CR/LF.  Rev 1.0      |
// +--------------------------------------------------------------------+
module hex_line_uart_tx
  import hex_line_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned BAUD        = 9600,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] data_i,
  input  logic        valid,
  output logic        ready,
  output logic        tx,
  output logic        busy
);

  localparam baud_cfg_t c_baud = baud_div(CLK_FREQ, BAUD);

  line_state_t r_state;
  logic [63:0] r_shreg;
  logic [2:0]  r_chars;
  logic        r_kick;
  logic        w_start;
  logic        w_done;
  logic [7:0]  w_byte;

  assign ready   = (r_state == S_IDLE);
  assign busy    = ~ready;
  // CR/LF raise start once on entry; character bytes start from LOAD.
  assign w_start = (r_state == S_LOAD) || r_kick;

  always_comb begin
    w_byte = r_shreg[63:56];
    case (r_state)
      S_CR:    w_byte = ASCII_CR;
      S_LF:    w_byte = ASCII_LF;
      default: w_byte = r_shreg[63:56];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_chars <= '0;
      r_kick  <= 1'b0;
    end else begin
      r_kick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_shreg <= data_i;
            r_chars <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_SEND;
        S_SEND: begin
          if (w_done) begin
            if (r_chars != 3'd7) begin
              r_shreg <= {r_shreg[55:0], 8'h00};
              r_chars <= r_chars + 3'd1;
              r_state <= S_LOAD;
            end else if (APPEND_CRLF) begin
              r_kick  <= 1'b1;
              r_state <= S_CR;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_CR: begin
          if (w_done) begin
            r_kick  <= 1'b1;
            r_state <= S_LF;
          end
        end
        S_LF: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (c_baud.div),
    .CNT_W    (c_baud.width)
  ) u_byte (
    .clk    (clk),
    .rstn   (rstn),
    .start  (w_start),
    .byte_i (w_byte),
    .tx     (tx),
    .done   (w_done)
  );

endmodule
`default_nettype wire
